// File: rtl/controle_multiciclo.sv
// Multicycle control unit for the 8-bit processor: sequences each instruction
// through BUSCA/DECOD/EXEC/MEM/ESCR and decodes the datapath control strobes.
module controle_multiciclo #(
  parameter int MEM_LAT = 1,
  parameter int FN_W    = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [2:0]      OPcode,
  input  logic [FN_W-1:0] BitVerificao,
  input  logic            Zero,
  output logic            EscrevMem,
  output logic            LerMem,
  output logic            Jump,
  output logic            Halt,
  output logic            EscrevReg,
  output logic            Beqz,
  output logic [1:0]      UlaOp,
  output logic [1:0]      FonteUla,
  output logic [FN_W-1:0] Funcao,
  output logic            EscrevPC,
  output logic            EscrevIR,
  output logic [2:0]      Estado
);

  typedef enum logic [2:0] {
    BUSCA  = 3'd0,
    DECOD  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    ESCR   = 3'd4,
    PARADO = 3'd5
  } estado_t;

  typedef enum logic [2:0] {
    C_LOAD,
    C_STORE,
    C_ALU,
    C_JUMP,
    C_BEQZ,
    C_HALT
  } classe_t;

  localparam logic [3:0] CNT_INI = 4'(MEM_LAT - 1);

  estado_t         state;
  estado_t         next_state;
  logic            ativo;
  logic [3:0]      cnt;
  logic [2:0]      op_q;
  logic [FN_W-1:0] fn_q;
  classe_t         classe_in;
  classe_t         classe_q;

  function automatic classe_t classificar(input logic [2:0] op, input logic [FN_W-1:0] fn);
    case (op)
      3'b000:  return C_LOAD;
      3'b101:  return C_STORE;
      3'b100:  return (fn == FN_W'(1)) ? C_ALU : C_JUMP;
      3'b110:  return C_BEQZ;
      3'b111: begin
        if (fn == FN_W'(0))      return C_HALT;
        else if (fn == FN_W'(3)) return C_JUMP;
        else                     return C_ALU;
      end
      default: return C_ALU;
    endcase
  endfunction

  assign classe_in = classificar(OPcode, BitVerificao);
  assign classe_q  = classificar(op_q, fn_q);

  // ativo stays low for the reset cycle and the one after it, so the first
  // BUSCA strobes appear one cycle after reset deasserts.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state <= BUSCA;
      ativo <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      fn_q  <= '0;
    end else begin
      ativo <= 1'b1;
      state <= next_state;
      if (state == DECOD) begin
        op_q <= OPcode;
        fn_q <= BitVerificao;
      end
      if (state == EXEC)
        cnt <= CNT_INI;
      else if (state == MEM && cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first; a path that skipped an
    // assignment would otherwise infer a latch.
    next_state = state;
    EscrevMem  = 1'b0;
    LerMem     = 1'b0;
    Jump       = 1'b0;
    Halt       = 1'b0;
    EscrevReg  = 1'b0;
    Beqz       = 1'b0;
    EscrevPC   = 1'b0;
    EscrevIR   = 1'b0;
    UlaOp      = 2'b00;
    FonteUla   = 2'b00;
    Funcao     = fn_q;
    Estado     = state;

    // ALU controls follow the decode register, so they hold through MEM/ESCR
    // and only change after the next DECOD.
    case (op_q)
      3'b001: begin UlaOp = 2'b01; FonteUla = 2'b10; end
      3'b010: begin UlaOp = 2'b00; FonteUla = 2'b01; end
      3'b100: if (fn_q == FN_W'(1)) UlaOp = 2'b10;
      3'b111: if (fn_q == FN_W'(1) || fn_q == FN_W'(2)) UlaOp = 2'b11;
      default: ;
    endcase

    if (ativo) begin
      case (state)
        BUSCA: begin
          EscrevIR   = 1'b1;
          EscrevPC   = 1'b1;
          next_state = DECOD;
        end
        DECOD: next_state = (classe_in == C_HALT) ? PARADO : EXEC;
        EXEC: begin
          case (classe_q)
            C_LOAD, C_STORE: next_state = MEM;
            C_ALU:           next_state = ESCR;
            C_JUMP: begin
              Jump       = 1'b1;
              EscrevPC   = 1'b1;
              next_state = BUSCA;
            end
            C_BEQZ: begin
              Beqz       = 1'b1;
              EscrevPC   = Zero;
              next_state = BUSCA;
            end
            default: next_state = BUSCA;
          endcase
        end
        MEM: begin
          if (classe_q == C_STORE) EscrevMem = 1'b1;
          else                     LerMem    = 1'b1;
          if (cnt == 4'd0)
            next_state = (classe_q == C_STORE) ? BUSCA : ESCR;
        end
        ESCR: begin
          EscrevReg  = 1'b1;
          next_state = BUSCA;
        end
        PARADO: Halt = 1'b1;
        default: next_state = BUSCA;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: stimulus pushes the hand-computed
// per-cycle output vector, a monitor pops and compares at each falling edge.
module tb_controle_multiciclo;

  localparam int LAT = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] OPcode;
  logic [1:0] BitVerificao;
  logic       Zero;
  logic       EscrevMem, LerMem, Jump, Halt, EscrevReg, Beqz, EscrevPC, EscrevIR;
  logic [1:0] UlaOp, FonteUla, Funcao;
  logic [2:0] Estado;

  controle_multiciclo #(.MEM_LAT(LAT), .FN_W(2)) dut (
    .clock(clock), .reset(reset), .OPcode(OPcode), .BitVerificao(BitVerificao),
    .Zero(Zero), .EscrevMem(EscrevMem), .LerMem(LerMem), .Jump(Jump), .Halt(Halt),
    .EscrevReg(EscrevReg), .Beqz(Beqz), .UlaOp(UlaOp), .FonteUla(FonteUla),
    .Funcao(Funcao), .EscrevPC(EscrevPC), .EscrevIR(EscrevIR), .Estado(Estado)
  );

  always #5 clock = ~clock;

  // Layout: estado, ir, pc, rd, wr, reg, jump, beqz, halt, ulaop, fonte, funcao
  typedef struct {
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [16:0] ev(int st, bit ir, bit pc, bit rd, bit wr, bit rg,
                                     bit jp, bit bq, bit ht, int ula, int fte, int fn);
    return {3'(st), ir, pc, rd, wr, rg, jp, bq, ht, 2'(ula), 2'(fte), 2'(fn)};
  endfunction

  wire [16:0] act = {Estado, EscrevIR, EscrevPC, LerMem, EscrevMem, EscrevReg,
                     Jump, Beqz, Halt, UlaOp, FonteUla, Funcao};

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s: got %05h expected %05h", e.name, act, e.v);
      end
    end
  end

  task automatic cyc(input string nm, input logic [2:0] op, input logic [1:0] fn,
                     input logic z, input logic rst, input logic [16:0] e);
    OPcode       = op;
    BitVerificao = fn;
    Zero         = z;
    reset        = rst;
    sb.push_back('{nm, e});
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [16:0] z0;
    z0 = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1; OPcode = '0; BitVerificao = '0; Zero = 1'b0;
    @(posedge clock); #1;

    cyc("reset_hold",    3'b000, 2'b00, 0, 1, z0);
    cyc("reset_release", 3'b010, 2'b00, 0, 0, z0);

    // Add 010/00; opcode corrupted after DECOD must not matter
    cyc("add_busca", 3'b010, 2'b00, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("add_decod", 3'b010, 2'b00, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("add_exec",  3'b111, 2'b00, 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc("add_escr",  3'b000, 2'b00, 0, 0, ev(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));

    // Load 000/00, MEM_LAT=3
    cyc("load_busca", 3'b000, 2'b00, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc("load_decod", 3'b000, 2'b00, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc("load_exec",  3'b101, 2'b10, 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < LAT; i++)
      cyc("load_mem", 3'b101, 2'b10, 0, 0, ev(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("load_escr",  3'b101, 2'b10, 0, 0, ev(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    // Store 101/10
    cyc("store_busca", 3'b101, 2'b10, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("store_decod", 3'b101, 2'b10, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("store_exec",  3'b001, 2'b11, 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    for (int i = 0; i < LAT; i++)
      cyc("store_mem", 3'b001, 2'b11, 0, 0, ev(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2));

    // SLT 001/11
    cyc("slt_busca", 3'b001, 2'b11, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    cyc("slt_decod", 3'b001, 2'b11, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    cyc("slt_exec",  3'b110, 2'b00, 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3));
    cyc("slt_escr",  3'b110, 2'b00, 0, 0, ev(4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2, 3));

    // Beqz taken (Zero=1)
    cyc("beqz1_busca", 3'b110, 2'b00, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 3));
    cyc("beqz1_decod", 3'b110, 2'b00, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3));
    cyc("beqz1_exec",  3'b110, 2'b00, 1, 0, ev(2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // Beqz not taken (Zero=0 only in EXEC)
    cyc("beqz0_busca", 3'b110, 2'b00, 1, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("beqz0_decod", 3'b110, 2'b00, 1, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("beqz0_exec",  3'b100, 2'b00, 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // Jump 100/00
    cyc("jump_busca", 3'b100, 2'b00, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jump_decod", 3'b100, 2'b00, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jump_exec",  3'b111, 2'b11, 0, 0, ev(2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    // JumpReg 111/11
    cyc("jr_busca", 3'b111, 2'b11, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jr_decod", 3'b111, 2'b11, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jr_exec",  3'b111, 2'b01, 0, 0, ev(2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3));

    // InveSin 111/01
    cyc("inv_busca", 3'b111, 2'b01, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    cyc("inv_decod", 3'b111, 2'b01, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    cyc("inv_exec",  3'b100, 2'b01, 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1));
    cyc("inv_escr",  3'b100, 2'b01, 0, 0, ev(4, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 1));

    // Setz 100/01
    cyc("setz_busca", 3'b100, 2'b01, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1));
    cyc("setz_decod", 3'b100, 2'b01, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1));
    cyc("setz_exec",  3'b000, 2'b00, 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1));
    cyc("setz_escr",  3'b000, 2'b00, 0, 0, ev(4, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 1));

    // Load aborted by reset in its 2nd MEM cycle
    cyc("abort_busca", 3'b000, 2'b00, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1));
    cyc("abort_decod", 3'b000, 2'b00, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1));
    cyc("abort_exec",  3'b000, 2'b00, 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("abort_mem1",  3'b000, 2'b00, 0, 0, ev(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("abort_mem2",  3'b000, 2'b00, 0, 1, ev(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("abort_reset", 3'b111, 2'b00, 0, 0, z0);

    // Halt 111/00: sticky until a one-cycle reset pulse
    cyc("halt_busca", 3'b111, 2'b00, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("halt_decod", 3'b111, 2'b00, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 22; i++)
      cyc("halt_hold", 3'(i), 2'(i), 1'(i), 1'(i == 21), ev(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("halt_reset", 3'b010, 2'b00, 0, 0, z0);
    cyc("post_busca", 3'b010, 2'b00, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clock);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
